serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial adder controller. Time-shares one instance of the team's 1-bit
//  full_adder gate-level cell across a WIDTH-bit addition. One bit is processed
//  per clock, LSB first, and the carry is held in a flip-flop between bits.
//  Sits between a requester (start/done handshake) and the full_adder datapath.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32.
// PORTS
//  clock    in   1      rising-edge clock
//  reset    in   1      synchronous, active-high reset
//  start    in   1      request pulse; sampled only when not busy
//  a        in   WIDTH  operand A; captured on the edge that accepts start
//  b        in   WIDTH  operand B; captured on the edge that accepts start
//  busy     out  1      high while the addition is in progress
//  done     out  1      one-cycle pulse; sum and cout are valid
//  sum      out  WIDTH  result; held until the next accepted start
//  cout     out  1      final carry-out; held with sum
// BEHAVIOUR
//  - One clock, clock. Reset is synchronous and active-high on reset.
//  - Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, bit count=0,
//    carry flop=0, operand shift regs=0.
//  - FSM states:
//    - IDLE: accept start -> RUN.
//    - RUN: bit count reaches WIDTH-1 -> DONE.
//    - DONE: held for exactly 1 cycle; start -> RUN, else -> IDLE.
//  - start is accepted in IDLE or DONE; it is ignored in RUN. No queuing and
//    no error flag.
//  - On accept: A_sr<=a, B_sr<=b, carry<=0, cnt<=0.
//  - RUN, each edge:
//    - full_adder(a=A_sr[0], b=B_sr[0], cin=carry) gives s and co.
//    - sum shifts right with s entering at the MSB.
//    - carry<=co; A_sr and B_sr shift right; cnt<=cnt+1.
//    - On the last bit (cnt==WIDTH-1): cout<=co, go to DONE.
//  - busy=1 exactly in RUN (registered). done=1 exactly in DONE (registered).
//  - Latency: start sampled at edge k. Bits are processed at edges
//    k+1..k+WIDTH. done is high in the cycle after edge k+WIDTH.
//    Issue interval is WIDTH+1 cycles when start is held in the DONE cycle.
//  - sum and cout hold their last value in IDLE and DONE. Both are cleared to 0
//    at the next accept.
//  - Wrap-around: the result is mod 2^WIDTH. Overflow is reported only via cout.
//  - Reset mid-RUN aborts the operation: no done pulse; all regs return to reset
//    values on the same edge.
//  - reset and start in the same cycle: reset wins and start is dropped.
//  - Timing: the combinational path is 3 gate delays (3 ns) from the carry flop
//    to D. The clock period in sim is >= 10 ns.
// CONFIGURATION
//  - SERIAL_SUB_EN defined:
//    - Adds input port sub (1 bit), captured with a and b on accept.
//    - With sub=1: B_sr<=~b and the carry flop starts at 1. sum = a-b mod 2^WIDTH;
//      cout=1 means no borrow (a>=b unsigned).
//    - With sub=0: identical to the add-only behaviour.
//  - SERIAL_SUB_EN undefined: no sub port; the carry always starts at 0.
// TESTING
//  - WIDTH=8, a=0x35, b=0x4A, start at edge 0:
//    busy high for edges 1..8, done at cycle 9, sum=0x7F, cout=0.
//  - a=0xFF, b=0x01: sum=0x00, cout=1. a=0xFF, b=0xFF: sum=0xFE, cout=1.
//  - start a=0x01, b=0x02. At edge 3, start with a=0xF0, b=0x0F:
//    the second start is ignored; done once with sum=0x03; no second done.
//  - Start a=0x35, b=0x4A. Assert reset at edge 4:
//    busy=0, sum=0, cout=0 on the next cycle; no done pulse ever follows.
//  - Back-to-back: start held through the done cycle with new a=0x80, b=0x80:
//    the first result is 0x7F. The second done follows 9 cycles later with
//    sum=0x00, cout=1.
//  - SERIAL_SUB_EN, sub=1:
//    a=0x10, b=0x01 gives sum=0x0F, cout=1.
//    a=0x00, b=0x01 gives sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one full-adder cell shared LSB-first over WIDTH clocks.
// Optional macro SERIAL_SUB_EN adds a sub port (a-b via inverted b and carry-in of 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic sub_i, accept, last, fa_s, fa_co;
`ifdef SERIAL_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif
  // the single shared full-adder cell, fed from the shift-register LSBs and the carry flop
  assign fa_s   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign fa_co  = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
  assign accept = start && (state_q != RUN);
  assign last   = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (accept) begin
      state_d = RUN;
      a_sr_d  = a;
      b_sr_d  = sub_i ? ~b : b;
      carry_d = sub_i;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
    end else if (state_q == RUN) begin
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      carry_d = fa_co;
      a_sr_d  = a_sr_q >> 1;
      b_sr_d  = b_sr_q >> 1;
      cnt_d   = cnt_q + 1'b1;
      cout_d  = last ? fa_co : cout_q;
      state_d = last ? DONE : RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
